rv32m_div_unit: RTL
===================

Name: rv32m_div_unit

Overview:
- Multi-cycle integer divider for the RV32IM multi-cycle datapath.
- Executes DIV, DIVU, REM and REMU.
- Drives the datapath `stall` signal while iterating, exposes `div_cycles` for debug, and provides `pipe_quo` and `pipe_rem` to the writeback mux.
- Sits directly downstream of the decode/operand-fetch stage; `start` is issued when decode sees an M-extension divide.

Parameters:
- BITS_PER_CYCLE, 4, quotient bits resolved per iteration cycle. Legal values: 2, 4, 8.
- ITER, 32/BITS_PER_CYCLE, number of iteration cycles. Derived; not overridden.

Ports:
- clock_proc  in  1   processor clock; all state updates on its rising edge
- rst  in  1   reset; synchronous, active-high
- start  in  1   request division; sampled only in IDLE
- op  in  2   funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU
- dividend  in  32  rs1 value
- divisor  in  32  rs2 value
- stall  out  1   high while an operation is in flight
- done  out  1   one-cycle pulse; results valid
- pipe_quo  out  32  quotient (signed or unsigned per op)
- pipe_rem  out  32  remainder (signed or unsigned per op)
- result  out  32  pipe_quo for op[1]=0, pipe_rem for op[1]=1
- div_cycles  out  4   iteration counter; 0 outside DIVIDE

Behaviour:
- Reset: all of the following are 0 at the edge where rst=1: state=IDLE, stall, done, pipe_quo, pipe_rem, result, div_cycles.
  - rst overrides every other input, including mid-operation; the in-flight operation is discarded and no done is produced.
- States: IDLE, DIVIDE, FINISH.
- IDLE, with start=1 at edge E0: latch op, the operand signs, and |dividend| and |divisor|; absolute values are taken only for signed ops (op[0]=0). Then:
  - divisor==0: go to FINISH with q=0xFFFFFFFF, r=dividend.
  - signed op, dividend==0x80000000, divisor==0xFFFFFFFF: go to FINISH with q=0x80000000, r=0.
  - otherwise: go to DIVIDE with div_cycles=0, partial remainder=0.
- DIVIDE: each edge performs BITS_PER_CYCLE restoring steps, MSB first, and increments div_cycles.
  - The edge where div_cycles==ITER-1 moves to FINISH and clears div_cycles.
- FINISH, one edge:
  - Apply sign correction for signed ops: negate q if the operand signs differ; r takes the dividend's sign.
  - Register pipe_quo, pipe_rem and result; set done=1; go to IDLE.
- done is high for exactly one cycle; it clears on the next edge.
- pipe_quo, pipe_rem and result hold their values until the next FINISH or rst.
- stall is high from E0 until the FINISH edge and is low in the cycle where done=1.
  - Normal latency: done asserted after edge E0+ITER+1 (ITER+1 cycles of stall).
  - Special-case latency: done after edge E0+1.
- start while not IDLE: ignored; operands and op are not re-latched.
- start in the same cycle as done (state is IDLE): accepted. Back-to-back operations have no bubble.
- Width rules:
  - Partial remainder is 33 bits; each trial subtract is 33-bit, and bit 32 selects restore.
  - All negations are two's complement modulo 2^32.

Decomposition:
- Shared package rv32m_pkg:
  - op encodings DIV_OP=2'b00, DIVU_OP=2'b01, REM_OP=2'b10, REMU_OP=2'b11.
  - state enum {IDLE, DIVIDE, FINISH}.
  - constants INT_MIN=32'h8000_0000 and ALL_ONES=32'hFFFF_FFFF.
- Sub-module div_step: combinational single restoring step.
  - Inputs: 33-bit remainder, next dividend bit, 32-bit divisor.
  - Outputs: new remainder, quotient bit.
  - rv32m_div_unit chains BITS_PER_CYCLE instances per cycle.

Test Plan:
- DIVU 100/7, BITS_PER_CYCLE=4 -> stall high 9 cycles; div_cycles 0..7; done after edge E0+9; pipe_quo=14, pipe_rem=2.
- DIV 0xFFFFFFF9(-7)/2 -> pipe_quo=0xFFFFFFFD, pipe_rem=0xFFFFFFFF. REM same operands -> result=0xFFFFFFFF. REMU same operands -> result=1.
- DIV 5/0 -> done after E0+1; pipe_quo=0xFFFFFFFF; pipe_rem=5; div_cycles never leaves 0.
- DIV 0x80000000/0xFFFFFFFF -> done after E0+1; pipe_quo=0x80000000; pipe_rem=0. DIVU same operands -> normal latency, q=0, r=0x80000000.
- Start DIVU 1000/3, then pulse rst when div_cycles==4 -> no done; all outputs 0; the next start 9/4 completes with q=2, r=1.
- start held high with changing operands during DIVIDE -> ignored. New start in the done cycle -> accepted; second done exactly ITER+1 cycles later.

Source files
------------

// File: rtl/rv32m_pkg.sv
// Shared definitions for the RV32M divide unit: op encodings, FSM states and
// the 32-bit constants used by the divide-by-zero and overflow shortcuts.
package rv32m_pkg;

   localparam logic [1:0] DIV_OP  = 2'b00;
   localparam logic [1:0] DIVU_OP = 2'b01;
   localparam logic [1:0] REM_OP  = 2'b10;
   localparam logic [1:0] REMU_OP = 2'b11;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      DIVIDE = 2'd1,
      FINISH = 2'd2
   } div_state_e;

   localparam logic [31:0] INT_MIN  = 32'h8000_0000;
   localparam logic [31:0] ALL_ONES = 32'hFFFF_FFFF;

   // Two's complement negation modulo 2^32.
   function automatic logic [31:0] neg32(input logic [31:0] value);
      return 32'd0 - value;
   endfunction

endpackage

// File: rtl/rv32m_div_unit_div_step.sv
// One restoring-division step: shift in the next dividend bit, trial-subtract
// the divisor and keep the difference only when it does not go negative.
module div_step
   import rv32m_pkg::*;
(
   input  logic [32:0] rem_in,
   input  logic        dividend_bit,
   input  logic [31:0] divisor,
   output logic [32:0] rem_out,
   output logic        quo_bit
);

   logic [32:0] shifted_s;
   logic [32:0] trial_s;
   logic        unused_msb_s;

   // The incoming remainder is always below the divisor, so its bit 32 is zero.
   assign unused_msb_s = rem_in[32];
   assign shifted_s    = {rem_in[31:0], dividend_bit};
   assign trial_s      = shifted_s - {1'b0, divisor};

   // Bit 32 of the trial difference flags a borrow, meaning restore.
   always_comb begin
      rem_out = shifted_s;
      quo_bit = 1'b0;
      if (trial_s[32]) begin
         rem_out = shifted_s;
         quo_bit = 1'b0;
      end else begin
         rem_out = trial_s;
         quo_bit = 1'b1;
      end
   end

endmodule

// File: rtl/rv32m_div_unit.sv
// Multi-cycle RV32M divider (DIV/DIVU/REM/REMU) resolving BITS_PER_CYCLE
// quotient bits per cycle; stalls the datapath while iterating.
module rv32m_div_unit
   import rv32m_pkg::*;
#(
   parameter int BITS_PER_CYCLE = 4
) (
   input  logic        clock_proc,
   input  logic        rst,
   input  logic        start,
   input  logic [1:0]  op,
   input  logic [31:0] dividend,
   input  logic [31:0] divisor,
   output logic        stall,
   output logic        done,
   output logic [31:0] pipe_quo,
   output logic [31:0] pipe_rem,
   output logic [31:0] result,
   output logic [3:0]  div_cycles
);

   localparam int         ITER       = 32 / BITS_PER_CYCLE;
   localparam logic [3:0] LAST_CYCLE = 4'(ITER - 1);

   div_state_e  state_r;
   logic        rem_sel_r;
   logic        neg_quo_r;
   logic        neg_rem_r;
   logic [31:0] dvd_r;
   logic [31:0] dvs_r;
   logic [32:0] rem_r;
   logic [3:0]  div_cycles_r;
   logic        stall_r;
   logic        done_r;
   logic [31:0] pipe_quo_r;
   logic [31:0] pipe_rem_r;
   logic [31:0] result_r;

   logic                      signed_op_s;
   logic                      sign_dvd_s;
   logic                      sign_dvs_s;
   logic [31:0]               abs_dvd_s;
   logic [31:0]               abs_dvs_s;
   logic                      div_zero_s;
   logic                      overflow_s;
   logic [BITS_PER_CYCLE-1:0] qbits_s;
   logic [32:0]               rem_next_s;
   logic [31:0]               dvd_next_s;
   logic [31:0]               fin_quo_s;
   logic [31:0]               fin_rem_s;

   assign signed_op_s = ~op[0];
   assign sign_dvd_s  = signed_op_s & dividend[31];
   assign sign_dvs_s  = signed_op_s & divisor[31];
   assign abs_dvd_s   = sign_dvd_s ? neg32(dividend) : dividend;
   assign abs_dvs_s   = sign_dvs_s ? neg32(divisor) : divisor;
   assign div_zero_s  = (divisor == 32'd0);
   assign overflow_s  = signed_op_s & (dividend == INT_MIN) & (divisor == ALL_ONES);

   // dvd_r doubles as the quotient register: dividend bits leave at the top
   // while resolved quotient bits enter at the bottom.
   for (genvar g = 0; g < BITS_PER_CYCLE; g++) begin : g_step
      logic [32:0] rem_in_s;
      logic [32:0] rem_out_s;
      if (g == 0) begin : g_first
         assign rem_in_s = rem_r;
      end else begin : g_chain
         assign rem_in_s = g_step[g-1].rem_out_s;
      end
      div_step u_div_step (
         .rem_in       (rem_in_s),
         .dividend_bit (dvd_r[31-g]),
         .divisor      (dvs_r),
         .rem_out      (rem_out_s),
         .quo_bit      (qbits_s[BITS_PER_CYCLE-1-g])
      );
   end

   assign rem_next_s = g_step[BITS_PER_CYCLE-1].rem_out_s;
   assign dvd_next_s = {dvd_r[31-BITS_PER_CYCLE:0], qbits_s};

   // Sign correction; the shortcut results arrive with both negate flags clear.
   always_comb begin
      fin_quo_s = dvd_r;
      fin_rem_s = rem_r[31:0];
      if (neg_quo_r) begin
         fin_quo_s = neg32(dvd_r);
      end else begin
         fin_quo_s = dvd_r;
      end
      if (neg_rem_r) begin
         fin_rem_s = neg32(rem_r[31:0]);
      end else begin
         fin_rem_s = rem_r[31:0];
      end
   end

   // Control FSM together with the datapath and output registers.
   always_ff @(posedge clock_proc) begin
      if (rst) begin
         state_r      <= IDLE;
         rem_sel_r    <= 1'b0;
         neg_quo_r    <= 1'b0;
         neg_rem_r    <= 1'b0;
         dvd_r        <= 32'd0;
         dvs_r        <= 32'd0;
         rem_r        <= 33'd0;
         div_cycles_r <= 4'd0;
         stall_r      <= 1'b0;
         done_r       <= 1'b0;
         pipe_quo_r   <= 32'd0;
         pipe_rem_r   <= 32'd0;
         result_r     <= 32'd0;
      end else begin
         case (state_r)
            IDLE: begin
               done_r <= 1'b0;
               if (start) begin
                  rem_sel_r    <= op[1];
                  stall_r      <= 1'b1;
                  div_cycles_r <= 4'd0;
                  dvs_r        <= abs_dvs_s;
                  if (div_zero_s) begin
                     dvd_r     <= ALL_ONES;
                     rem_r     <= {1'b0, dividend};
                     neg_quo_r <= 1'b0;
                     neg_rem_r <= 1'b0;
                     state_r   <= FINISH;
                  end else if (overflow_s) begin
                     dvd_r     <= INT_MIN;
                     rem_r     <= 33'd0;
                     neg_quo_r <= 1'b0;
                     neg_rem_r <= 1'b0;
                     state_r   <= FINISH;
                  end else begin
                     dvd_r     <= abs_dvd_s;
                     rem_r     <= 33'd0;
                     neg_quo_r <= sign_dvd_s ^ sign_dvs_s;
                     neg_rem_r <= sign_dvd_s;
                     state_r   <= DIVIDE;
                  end
               end else begin
                  stall_r <= 1'b0;
               end
            end
            DIVIDE: begin
               done_r <= 1'b0;
               dvd_r  <= dvd_next_s;
               rem_r  <= rem_next_s;
               if (div_cycles_r == LAST_CYCLE) begin
                  div_cycles_r <= 4'd0;
                  state_r      <= FINISH;
               end else begin
                  div_cycles_r <= div_cycles_r + 4'd1;
               end
            end
            FINISH: begin
               pipe_quo_r <= fin_quo_s;
               pipe_rem_r <= fin_rem_s;
               result_r   <= rem_sel_r ? fin_rem_s : fin_quo_s;
               done_r     <= 1'b1;
               stall_r    <= 1'b0;
               state_r    <= IDLE;
            end
            default: begin
               state_r      <= IDLE;
               stall_r      <= 1'b0;
               done_r       <= 1'b0;
               div_cycles_r <= 4'd0;
            end
         endcase
      end
   end

   assign stall      = stall_r;
   assign done       = done_r;
   assign pipe_quo   = pipe_quo_r;
   assign pipe_rem   = pipe_rem_r;
   assign result     = result_r;
   assign div_cycles = div_cycles_r;

endmodule
